cska_mp_sequencer: RTL and testbench
====================================

# cska_mp_sequencer

Multi-precision add/subtract sequencer built around one shared `CSKA32` carry-skip adder. It accepts wide operands (`32*WORDS` bits) through a valid/ready handshake. It then streams them through the 32-bit adder one word per cycle, least-significant word first, chaining each word's carry-out into the next word's carry-in. The registered wide result, carry and signed overflow are returned on a second valid/ready handshake. It sits between a wide-arithmetic requester and the existing 32-bit adder, so the adder datapath needs no change.

## Interface
- `WORDS`, 4, number of 32-bit words per operand; legal range 2–16; operand width `W = 32*WORDS`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  requester presents an operation.
- `in_ready`  out  1  sequencer can accept an operation (high only in IDLE).
- `op_a`  in  W  operand A.
- `op_b`  in  W  operand B.
- `op_cin`  in  1  carry-in for add mode; ignored in subtract mode.
- `op_sub`  in  1  1 = compute A − B (two's complement), 0 = compute A + B + cin.
- `out_valid`  out  1  result registers hold a completed operation.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  W  sum or difference.
- `cout`  out  1  carry-out of the most-significant word; in subtract mode, 1 = no borrow.
- `ovf`  out  1  signed overflow of the full W-bit operation.
- `busy`  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - Latch `op_a` into `a_q`.
    - Latch `op_sub ? ~op_b : op_b` into `b_q`.
    - Set carry register `c_q` = `op_sub ? 1 : op_cin`.
    - Clear word index `idx` to 0.
    - Go to RUN.
- RUN, each cycle:
  - The adder sees `operA = a_q[32*idx +: 32]`, `operB = b_q[32*idx +: 32]`, `Cin = c_q`.
  - `resultOUT` is written into `result[32*idx +: 32]`.
  - `c_q` <= `Cout`.
  - `idx` increments.
- RUN, on `idx == WORDS-1`:
  - `cout` <= adder `Cout`.
  - `ovf` <= (`a_q[W-1] == b_q[W-1]`) & (`resultOUT[31] != a_q[W-1]`), using the post-inversion `b_q`.
  - Go to DONE.
- DONE:
  - `out_valid` = 1.
  - `result`, `cout` and `ovf` are held stable until `out_ready` is sampled high.
  - Then go to IDLE.
  - No new operation is accepted in DONE, even if `in_valid` is high.
- The adder is a single combinational `CSKA32` instance. It is driven with zeros outside RUN, and its outputs are ignored there.
- `idx` width is `$clog2(WORDS)`; it never wraps within one operation.
- `result` words not yet written in RUN keep their previous value. The consumer observes `result` only while `out_valid` is high.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `result` = 0, `cout` = 0, `ovf` = 0. Internally `idx` = 0, `c_q` = 0.
- Latency: with acceptance at edge *n*, `out_valid` rises after edge *n+WORDS* (WORDS cycles in RUN).
- With `out_ready` held high, the result is consumed at the first DONE edge. `in_ready` then rises one cycle later.
- Throughput: one operation per WORDS+2 cycles.
- Handshake rules:
  - `in_ready` and `out_valid` are registered-state decodes, never combinational on `in_valid` or `out_ready`.
  - `in_ready` and `out_valid` are never high together.
- Backpressure: with `out_ready` low, DONE persists indefinitely and all outputs stay frozen.
- Reset mid-operation (RUN or DONE): at the next edge, everything returns to reset values and the partial result is discarded.
- Operand changes on `op_a`, `op_b`, `op_sub` or `op_cin` after acceptance have no effect on the operation in flight.
- The critical path is a single `CSKA32` carry chain plus the word-select mux per cycle.

## Test plan
- WORDS=4, A=`0x0000_0000_0000_0000_0000_0000_FFFF_FFFF`, B=1, add, cin=0:
  - Result=`0x...0000_0001_0000_0000` (bit 32 set, all else 0).
  - cout=0, ovf=0.
  - Carry propagates from word 0 to word 1.
  - `out_valid` rises exactly 4 cycles after acceptance.
- A=all-ones, B=all-ones, add, cin=1 -> result=all-ones, cout=1, ovf=0.
- A=`0x7FFF…FFFF`, B=1, add -> result=`0x8000…0000`, cout=0, ovf=1.
- Subtract A=5, B=7 -> result=`0xFFFF…FFFE` (−2), cout=0 (borrow), ovf=0.
- Subtract A=7, B=5 -> result=2, cout=1.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 and new operands applied.
  - Outputs stay frozen and `in_ready` stays 0.
  - On release, the second operation is accepted and produces its own correct result.
- Assert `rst` during the 2nd RUN cycle -> next cycle IDLE, all outputs 0, `in_ready`=1. A fresh operation afterwards completes correctly.

Source files
------------

// File: rtl/cska_mp_sequencer.sv
// cska_mp_sequencer: multi-precision add/subtract streamed word-serially through one CSKA32 carry-skip adder
module CSKA32 (
    input  logic [31:0] operA,
    input  logic [31:0] operB,
    input  logic        Cin,
    output logic [31:0] resultOUT,
    output logic        Cout
);
    logic [8:0] c;
    assign c[0] = Cin;
    assign Cout = c[8];
    for (genvar g = 0; g < 8; g++) begin : blk
        logic [4:0] rc;
        logic [3:0] p;
        assign rc[0] = c[g];
        for (genvar i = 0; i < 4; i++) begin : bit_g
            assign p[i] = operA[4*g+i] ^ operB[4*g+i];
            assign resultOUT[4*g+i] = p[i] ^ rc[i];
            assign rc[i+1] = (operA[4*g+i] & operB[4*g+i]) | (p[i] & rc[i]);
        end
        // a fully propagating block forwards its carry-in past the ripple chain
        assign c[g+1] = (&p) ? c[g] : rc[4];
    end
endmodule

module cska_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*WORDS-1:0] op_a,
    input  logic [32*WORDS-1:0] op_b,
    input  logic              op_cin,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*WORDS-1:0] result,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);
    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0]  a_q, b_q;
    logic          c_q;
    logic [IW-1:0] idx;
    logic [31:0]   add_a, add_b, add_s;
    logic          add_ci, add_co, last;

    assign in_ready  = state == IDLE;
    assign busy      = state == RUN;
    assign out_valid = state == DONE;
    assign last      = idx == IW'(WORDS - 1);

    always_comb begin
        add_a   = busy ? a_q[32*idx +: 32] : '0;
        add_b   = busy ? b_q[32*idx +: 32] : '0;
        add_ci  = busy ? c_q : 1'b0;
        state_n = (in_ready && in_valid) ? RUN :
                  (busy && last)         ? DONE :
                  (out_valid && out_ready) ? IDLE : state;
    end

    CSKA32 u_add (
        .operA(add_a),
        .operB(add_b),
        .Cin(add_ci),
        .resultOUT(add_s),
        .Cout(add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_n;
            if (in_ready && in_valid) begin
                a_q <= op_a;
                b_q <= op_sub ? ~op_b : op_b;
                c_q <= op_sub | op_cin;
                idx <= '0;
            end else if (busy) begin
                result[32*idx +: 32] <= add_s;
                c_q <= add_co;
                if (last) begin
                    cout <= add_co;
                    ovf  <= (a_q[W-1] == b_q[W-1]) & (add_s[31] != a_q[W-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cska_mp_sequencer.sv
// tb_cska_mp_sequencer: directed self-checking bench for the WORDS=4 sequencer
module tb_cska_mp_sequencer;
    logic         clk = 0, rst = 1;
    logic         in_valid = 0, in_ready, op_cin = 0, op_sub = 0;
    logic [127:0] op_a = '0, op_b = '0, result;
    logic         out_valid, out_ready = 0, cout, ovf, busy;
    int           compared = 0, mismatched = 0;
    logic [127:0] r, held;
    logic         co, ov;
    int           lat;

    always #5 clk = ~clk;

    cska_mp_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic cin, input logic sub,
                         output logic [127:0] res, output logic c, output logic o, output int l);
        wait_ready();
        op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1;
        step();
        in_valid = 0;
        op_a = '1; op_b = 128'h5a5a; op_cin = ~cin; op_sub = ~sub;
        chk("busy_in_run", {127'd0, busy}, 128'd1);
        wait_valid(l);
        res = result; c = cout; o = ovf;
        out_ready = 1;
        step();
        out_ready = 0;
        chk("idle_after_consume", {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_result", result, 128'd0);
        chk("rst_flags", {126'd0, cout, ovf}, 128'd0);
        rst = 0;
        step();

        do_op(128'hFFFF_FFFF, 128'd1, 0, 0, r, co, ov, lat);
        chk("t1_result", r, 128'h1_0000_0000);
        chk("t1_flags", {126'd0, co, ov}, 128'd0);
        chk("t1_latency", 128'(lat), 128'd4);

        do_op('1, '1, 1, 0, r, co, ov, lat);
        chk("t2_result", r, '1);
        chk("t2_flags", {126'd0, co, ov}, 128'd2);

        do_op({1'b0, {127{1'b1}}}, 128'd1, 0, 0, r, co, ov, lat);
        chk("t3_result", r, {1'b1, 127'd0});
        chk("t3_flags", {126'd0, co, ov}, 128'd1);

        do_op(128'd5, 128'd7, 0, 1, r, co, ov, lat);
        chk("t4_result", r, {{124{1'b1}}, 4'hE});
        chk("t4_flags", {126'd0, co, ov}, 128'd0);

        do_op(128'd7, 128'd5, 1, 1, r, co, ov, lat);
        chk("t5_result", r, 128'd2);
        chk("t5_flags", {126'd0, co, ov}, 128'd2);

        wait_ready();
        op_a = 128'h1234_0000_0000_0000_0000_1234; op_b = 128'h1111_0000_0000_0000_0000_1111;
        op_cin = 0; op_sub = 0; in_valid = 1;
        step();
        op_a = 128'd100; op_b = 128'd1; op_sub = 1;
        wait_valid(lat);
        chk("bp_latency", 128'(lat), 128'd4);
        held = result;
        chk("bp_result", held, 128'h2345_0000_0000_0000_0000_2345);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_frozen", result, held);
            chk("bp_in_ready", {126'd0, in_ready, out_valid}, 128'd1);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
        step();
        in_valid = 0;
        chk("bp_second_accepted", {127'd0, busy}, 128'd1);
        wait_valid(lat);
        chk("bp2_latency", 128'(lat), 128'd4);
        chk("bp2_result", result, 128'd99);
        chk("bp2_flags", {126'd0, cout, ovf}, 128'd2);
        out_ready = 1;
        step();
        out_ready = 0;

        wait_ready();
        op_a = 128'd10; op_b = 128'd20; op_cin = 0; op_sub = 0; in_valid = 1;
        step();
        in_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("mr_in_ready", {127'd0, in_ready}, 128'd1);
        chk("mr_state", {126'd0, out_valid, busy}, 128'd0);
        chk("mr_result", result, 128'd0);
        chk("mr_flags", {126'd0, cout, ovf}, 128'd0);

        do_op(128'd3, 128'd4, 1, 0, r, co, ov, lat);
        chk("mr_fresh_result", r, 128'd8);
        chk("mr_fresh_latency", 128'(lat), 128'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
